// File: rtl/palette_arbiter.sv
// palette_arbiter
// Arbitrates NUM_REQ requesters onto one shared combinational palette through
// a two-stage pipeline: stage 1 registers the winner's index, and stage 2
// registers the palette colour together with the winner's id. The response
// uses a valid/ready handshake, and backpressure freezes the whole pipeline.
// Build option: define PALETTE_ARB_RR_EN for round-robin arbitration. When it
// is not defined, the block uses fixed priority and the lowest index wins.
module palette_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 4,
   parameter int COLOR_W = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*IDX_W-1:0]     req_index,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [IDX_W-1:0]             pal_index,
   input  logic [COLOR_W-1:0]           pal_red,
   input  logic [COLOR_W-1:0]           pal_green,
   input  logic [COLOR_W-1:0]           pal_blue,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [COLOR_W-1:0]           rsp_red,
   output logic [COLOR_W-1:0]           rsp_green,
   output logic [COLOR_W-1:0]           rsp_blue
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Returns (base + k) mod NUM_REQ. Here k is always less than NUM_REQ.
   function automatic logic [ID_W-1:0] f_rot(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s[ID_W-1:0];
   endfunction

   logic                r_s1_valid;
   logic [ID_W-1:0]     r_s1_id;
   logic [IDX_W-1:0]    r_pal_index;
   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [COLOR_W-1:0]  r_rsp_red;
   logic [COLOR_W-1:0]  r_rsp_green;
   logic [COLOR_W-1:0]  r_rsp_blue;

   logic                w_adv;
   logic                w_any;
   logic [ID_W-1:0]     w_base;
   logic [ID_W-1:0]     w_win_id;
   logic [IDX_W-1:0]    w_win_index;

   // The whole pipeline moves only when the output slot is empty or being consumed.
   assign w_adv = !r_rsp_valid || rsp_ready;

`ifdef PALETTE_ARB_RR_EN
   logic [ID_W-1:0]     r_ptr;

   assign w_base = r_ptr;

   // After each issued grant, the pointer moves to one past the winner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (w_adv && w_any) begin
         r_ptr <= (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
      end
   end
`else
   // With fixed priority the scan always starts at requester 0.
   assign w_base = '0;
`endif

   // Scan from the base upward and keep the first requester found. The loop
   // runs downward so that the last assignment made is the nearest one.
   always_comb begin
      w_any    = 1'b0;
      w_win_id = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[f_rot(w_base, k)]) begin
            w_any    = 1'b1;
            w_win_id = f_rot(w_base, k);
         end
      end
   end

   assign w_win_index = req_index[w_win_id*IDX_W +: IDX_W];

   // Decode the one-hot grant pulse. It is held off while the pipeline is stalled.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = w_adv && w_any && (w_win_id == ID_W'(gi));
   end

   // Stage 1 captures the winner. pal_index keeps its value on idle cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_id     <= '0;
         r_pal_index <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_any;
         if (w_any) begin
            r_s1_id     <= w_win_id;
            r_pal_index <= w_win_index;
         end
      end
   end

   // Stage 2 captures the palette colour that the stage-1 index looked up.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_red   <= '0;
         r_rsp_green <= '0;
         r_rsp_blue  <= '0;
      end else if (w_adv) begin
         r_rsp_valid <= r_s1_valid;
         r_rsp_id    <= r_s1_id;
         r_rsp_red   <= pal_red;
         r_rsp_green <= pal_green;
         r_rsp_blue  <= pal_blue;
      end
   end

   assign pal_index = r_pal_index;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_red   = r_rsp_red;
   assign rsp_green = r_rsp_green;
   assign rsp_blue  = r_rsp_blue;

endmodule

// File: doc/palette_arbiter.md
PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter IDX_W, default 4, palette index width.
REQ-003 The block SHALL have parameter COLOR_W, default 4, width of each colour channel.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port req  input  NUM_REQ  per-requester lookup request, bit i = requester i.
REQ-007 The block SHALL have port req_index  input  NUM_REQ*IDX_W  requester i index in bits [i*IDX_W +: IDX_W].
REQ-008 The block SHALL have port gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-009 The block SHALL have port pal_index  output  IDX_W  registered index driven to the shared combinational palette.
REQ-010 The block SHALL have ports pal_red, pal_green, pal_blue  input  COLOR_W each  palette colour for pal_index, same cycle.
REQ-011 The block SHALL have port rsp_valid  output  1  response valid.
REQ-012 The block SHALL have port rsp_ready  input  1  response consumer ready.
REQ-013 The block SHALL have port rsp_id  output  clog2(NUM_REQ)  requester owning the response.
REQ-014 The block SHALL have ports rsp_red, rsp_green, rsp_blue  output  COLOR_W each  registered looked-up colour.

Function
REQ-015 Pipeline advance SHALL be defined as adv = !rsp_valid || rsp_ready.
REQ-016 Stage 1: on a cycle with adv=1 and any req bit set, the block SHALL select one winner, pulse gnt for it in that cycle, and register s1_valid=1, s1_id=winner, pal_index=req_index of winner.
REQ-017 gnt SHALL be combinational from registered state and req, asserted only when adv=1; gnt SHALL be all-zero when adv=0 or req=0.
REQ-018 Stage 2: on a cycle with adv=1, rsp_valid SHALL load s1_valid, and rsp_id/rsp_red/rsp_green/rsp_blue SHALL load s1_id/pal_red/pal_green/pal_blue.
REQ-019 Latency SHALL be exactly 2 cycles from the gnt cycle to rsp_valid=1 when rsp_ready stays 1; throughput SHALL be one lookup per cycle.
REQ-020 When adv=0 (rsp_valid=1, rsp_ready=0), stage 1, stage 2, pal_index and the arbitration pointer SHALL hold unchanged and no grant SHALL issue.
REQ-021 A requester SHALL hold req and req_index stable until its gnt; each gnt SHALL consume exactly one lookup; a req held high after gnt SHALL be a new request.
REQ-022 With adv=1 and req=0, s1_valid SHALL load 0, and pal_index SHALL hold its previous value.
REQ-023 Responses SHALL be delivered in grant order; no response SHALL be dropped or duplicated under any rsp_ready pattern.

Reset
REQ-024 While reset_n=0, gnt=0, rsp_valid=0, s1_valid=0, rsp_id=0, rsp colours=0, pal_index=0 and the round-robin pointer=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight lookups; no rsp_valid SHALL appear for requests granted before reset.
REQ-026 The first grant SHALL be possible on the first rising clk edge after reset_n deasserts.

Configuration
REQ-027 Macro PALETTE_ARB_RR_EN defined: round-robin arbitration; the winner is the first requesting index at or after pointer, wrapping NUM_REQ-1 to 0, and the pointer SHALL become winner+1 (mod NUM_REQ) only on a cycle in which a grant issues.
REQ-028 PALETTE_ARB_RR_EN undefined: fixed priority, lowest requesting index wins; the pointer register SHALL not exist.
REQ-029 With PALETTE_ARB_RR_EN, a continuously requesting requester SHALL be granted within NUM_REQ grant cycles.

Verification
REQ-030 Single request: req=4'b0100, req_index[2]=4'h3, rsp_ready=1 -> gnt=4'b0100 at cycle T, pal_index=3 at T+1, rsp_valid=1 with rsp_id=2 and the colour for index 3 at T+2.
REQ-031 Contention, RR: req=4'b1111 held, rsp_ready=1 -> gnt sequence 0001,0010,0100,1000,0001; without the macro -> gnt=0001 every cycle.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles while rsp_valid=1 and req=4'b0011 -> gnt=0 and all outputs held; after rsp_ready=1, grants resume in order with no loss or duplication.
REQ-033 Wrap-around: RR pointer=3, req=4'b1001 -> requester 3 granted, pointer=0; next cycle requester 0 granted.
REQ-034 Reset mid-flight: reset_n low one cycle after a grant -> rsp_valid stays 0, all outputs 0; after release, a new request completes with 2-cycle latency.
